// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: takes a 16-bit little-endian word count followed by
// the program bytes, packs them into 32-bit words and writes them from 0x000 up.
module instr_mem_loader #(
   parameter int ADDR_W      = 12,
   parameter int DEPTH_WORDS = 1024,
   parameter int CNT_W       = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  words_loaded
);

   localparam int LEN_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_BYTE,
      S_WRITE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [1:0]        idx_q, idx_d;
   logic [31:0]       word_q, word_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [CNT_W-1:0]  words_q, words_d;

   logic              xfer;
   logic [LEN_W-1:0]  len_rx;
   logic [CNT_W-1:0]  words_inc;
   logic [31:0]       word_rx;

   // in_ready is the only output decoded straight from state.
   assign in_ready = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_BYTE);
   assign xfer     = in_valid & in_ready;
   assign len_rx   = {in_data, len_q[7:0]};
   assign words_inc = words_q + CNT_W'(1);

   always_comb begin
      word_rx = word_q;
      word_rx[8*idx_q +: 8] = in_data;
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      len_d       = len_q;
      idx_d       = idx_q;
      word_d      = word_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      busy_d      = busy_q;
      done_d      = done_q;
      error_d     = error_q;
      words_d     = words_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LEN0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               error_d = 1'b0;
               words_d = '0;
               ptr_d   = '0;
               len_d   = '0;
               idx_d   = '0;
            end
         end
         S_LEN0: begin
            if (xfer) begin
               len_d   = {len_q[15:8], in_data};
               state_d = S_LEN1;
            end
         end
         S_LEN1: begin
            if (xfer) begin
               len_d = len_rx;
               if (len_rx == '0) begin
                  state_d = S_DONE;
               end else if (len_rx > LEN_W'(DEPTH_WORDS)) begin
                  // Oversized loads are refused before any write so the pointer cannot wrap.
                  error_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  idx_d   = '0;
                  state_d = S_BYTE;
               end
            end
         end
         S_BYTE: begin
            if (xfer) begin
               word_d = word_rx;
               idx_d  = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = ptr_q;
                  mem_wdata_d = word_rx;
                  state_d     = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            ptr_d   = ptr_q + ADDR_W'(4);
            words_d = words_inc;
            if ({{(LEN_W-CNT_W){1'b0}}, words_inc} == len_q) state_d = S_DONE;
            else                                              state_d = S_BYTE;
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         word_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         words_q     <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         word_q      <= word_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         words_q     <= words_d;
      end
   end

   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign busy         = busy_q;
   assign cpu_hold     = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_q;

endmodule
